// File: rtl/dds_load_arbiter_if.sv
// Tuning-source and DDS-pin bundle for dds_load_arbiter.
// slave = arbiter side, master = tuning sources plus DDS pins.
interface dds_load_arbiter_if;
  logic        req_a;
  logic [27:0] freq_a;
  logic [11:0] phase_a;
  logic        ack_a;
  logic        req_b;
  logic [27:0] freq_b;
  logic [11:0] phase_b;
  logic        ack_b;
  logic        busy;
  logic        done;
  logic        owner;
  logic        FSYNC;
  logic        SCLK;
  logic        SDATA;

  modport slave (
    input  req_a, freq_a, phase_a,
    input  req_b, freq_b, phase_b,
    output ack_a, ack_b, busy, done, owner,
    output FSYNC, SCLK, SDATA
  );

  modport master (
    output req_a, freq_a, phase_a,
    output req_b, freq_b, phase_b,
    input  ack_a, ack_b, busy, done, owner,
    input  FSYNC, SCLK, SDATA
  );
endinterface

// File: rtl/dds_load_arbiter.sv
// Round-robin arbiter serialising DDS reload words for two tuning sources.
// Define DDS_PHASE_EN to include the phase word (5 words instead of 4).
module dds_load_arbiter #(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  dds_load_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE, S_GRANT, S_SHIFT, S_GAP
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [7:0] DIV_M2 =
    (CLK_DIV > 1) ? 8'(CLK_DIV - 2) : 8'd0;
`ifdef DDS_PHASE_EN
  localparam logic [2:0] LAST = 3'd4;
`else
  localparam logic [2:0] LAST = 3'd3;
`endif

  state_t      r_state;
  logic [27:0] r_freq;
  logic [15:0] r_sh;
  logic [7:0]  r_div;
  logic        r_half;
  logic [3:0]  r_bit;
  logic [2:0]  r_widx;
  logic [1:0]  r_req_q;
  logic        r_pend_a;
  logic        r_pend_b;
  logic        r_ack_a;
  logic        r_ack_b;
  logic        r_busy;
  logic        r_done;
  logic        r_owner;
  logic        r_fsync;
  logic        r_sclk;
  logic        r_sdata;

  logic        w_req_a;
  logic        w_req_b;
  logic        w_pick_b;
  logic        w_rise_a;
  logic        w_rise_b;
  logic        w_gap_pen;
  logic [2:0]  w_idx_ld;
  logic [15:0] w_word;

`ifdef DDS_PHASE_EN
  logic [11:0] r_phase;
`else
  logic        w_unused_phase;
  assign w_unused_phase = ^{bus.phase_a, bus.phase_b};
`endif

  // A pulse while busy is remembered so it is served later.
  assign w_rise_a = bus.req_a & ~r_req_q[0];
  assign w_rise_b = bus.req_b & ~r_req_q[1];
  assign w_req_a  = bus.req_a | r_pend_a;
  assign w_req_b  = bus.req_b | r_pend_b;
  assign w_pick_b = w_req_b & (~w_req_a | ~r_owner);

  assign w_gap_pen = (CLK_DIV == 1) ? ~r_half
                   : (r_half && r_div == DIV_M2);

  assign w_idx_ld = (r_state == S_GAP) ? r_widx + 3'd1 : 3'd0;

  always_comb begin
    w_word = 16'h2000;
    unique case (w_idx_ld)
      3'd0: w_word = 16'h2100;
      3'd1: w_word = {2'b01, r_freq[13:0]};
      3'd2: w_word = {2'b01, r_freq[27:14]};
`ifdef DDS_PHASE_EN
      3'd3: w_word = {4'hC, r_phase};
`endif
      default: w_word = 16'h2000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_freq   <= '0;
      r_sh     <= '0;
      r_div    <= '0;
      r_half   <= 1'b0;
      r_bit    <= '0;
      r_widx   <= '0;
      r_req_q  <= '0;
      r_pend_a <= 1'b0;
      r_pend_b <= 1'b0;
      r_ack_a  <= 1'b0;
      r_ack_b  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_owner  <= 1'b1;
      r_fsync  <= 1'b1;
      r_sclk   <= 1'b1;
      r_sdata  <= 1'b0;
`ifdef DDS_PHASE_EN
      r_phase  <= '0;
`endif
    end else begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      r_done  <= 1'b0;
      r_req_q <= {bus.req_b, bus.req_a};
      if (w_rise_a) r_pend_a <= 1'b1;
      if (w_rise_b) r_pend_b <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_req_a | w_req_b) begin
            r_state <= S_GRANT;
            r_busy  <= 1'b1;
            r_owner <= w_pick_b;
            if (w_pick_b) begin
              r_ack_b  <= 1'b1;
              r_pend_b <= 1'b0;
              r_freq   <= bus.freq_b;
`ifdef DDS_PHASE_EN
              r_phase  <= bus.phase_b;
`endif
            end else begin
              r_ack_a  <= 1'b1;
              r_pend_a <= 1'b0;
              r_freq   <= bus.freq_a;
`ifdef DDS_PHASE_EN
              r_phase  <= bus.phase_a;
`endif
            end
          end
        end
        S_GRANT: begin
          r_state <= S_SHIFT;
          r_widx  <= 3'd0;
          r_sh    <= w_word;
          r_sdata <= w_word[15];
          r_fsync <= 1'b0;
          r_sclk  <= 1'b1;
          r_bit   <= 4'd0;
          r_div   <= 8'd0;
          r_half  <= 1'b0;
        end
        S_SHIFT: begin
          if (r_div != DIV_M1) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div <= 8'd0;
            if (!r_half) begin
              r_half <= 1'b1;
              r_sclk <= 1'b0;
            end else begin
              r_half <= 1'b0;
              r_sclk <= 1'b1;
              r_bit  <= r_bit + 4'd1;
              if (r_bit == 4'd15) begin
                r_state <= S_GAP;
                r_fsync <= 1'b1;
                r_sdata <= 1'b0;
              end else begin
                r_sh    <= r_sh << 1;
                r_sdata <= r_sh[14];
              end
            end
          end
        end
        S_GAP: begin
          if (w_gap_pen && r_widx == LAST) r_done <= 1'b1;
          if (r_div != DIV_M1) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div <= 8'd0;
            if (!r_half) begin
              r_half <= 1'b1;
            end else if (r_widx == LAST) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_half  <= 1'b0;
            end else begin
              r_state <= S_SHIFT;
              r_widx  <= r_widx + 3'd1;
              r_sh    <= w_word;
              r_sdata <= w_word[15];
              r_fsync <= 1'b0;
              r_bit   <= 4'd0;
              r_half  <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack_a = r_ack_a;
  assign bus.ack_b = r_ack_b;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.owner = r_owner;
  assign bus.FSYNC = r_fsync;
  assign bus.SCLK  = r_sclk;
  assign bus.SDATA = r_sdata;

endmodule

// File: tb/tb_dds_load_arbiter.sv
// Directed bench for dds_load_arbiter: u0 at CLK_DIV=2, u1 at CLK_DIV=1.
// Words are rebuilt from SDATA on each SCLK fall while FSYNC is low.
module tb_dds_load_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  dds_load_arbiter_if d0();
  dds_load_arbiter_if d1();

  dds_load_arbiter #(.CLK_DIV(2)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(d0.slave)
  );
  dds_load_arbiter #(.CLK_DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(d1.slave)
  );

`ifdef DDS_PHASE_EN
  localparam int NW = 5;
`else
  localparam int NW = 4;
`endif
  localparam int T0 = 1 + 34 * 2 * NW;
  localparam int T1 = 1 + 34 * 1 * NW;

  int vecs = 0;
  int errs = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] s0, s1;
  int n0 = 0, n1 = 0, b0 = 0, b1 = 0, na0 = 0;
  logic p0 = 1'b1, p1 = 1'b1;

  always @(negedge clk) begin
    if (!rst_n || d0.FSYNC) n0 = 0;
    else if (p0 && !d0.SCLK) begin
      s0 = {s0[14:0], d0.SDATA};
      n0++;
      if (n0 == 16) begin q0.push_back(s0); n0 = 0; end
    end
    p0 = d0.SCLK;
    if (d0.busy) b0++;
    if (d0.ack_a) na0++;
    if (!rst_n || d1.FSYNC) n1 = 0;
    else if (p1 && !d1.SCLK) begin
      s1 = {s1[14:0], d1.SDATA};
      n1++;
      if (n1 == 16) begin q1.push_back(s1); n1 = 0; end
    end
    p1 = d1.SCLK;
    if (d1.busy) b1++;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic sig(int s);
    case (s)
      0: return d0.ack_a;
      1: return d0.ack_b;
      2: return d0.done;
      3: return d1.ack_b;
      default: return d1.done;
    endcase
  endfunction

  task automatic wait_for(int s, string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig(s) && n < 2000);
    chk(tag, 32'(sig(s)), 32'd1);
  endtask

  task automatic chk_seq(string tag, logic [15:0] q[$],
                         logic [15:0] w1, logic [15:0] w2,
                         logic [15:0] w3);
    logic [15:0] e[$];
    e = {16'h2100, w1, w2};
    if (NW == 5) e.push_back(w3);
    e.push_back(16'h2000);
    chk({tag, ".nwords"}, 32'(q.size()), 32'(NW));
    for (int i = 0; i < NW; i++)
      chk($sformatf("%s.w%0d", tag, i),
          (i < q.size()) ? 32'(q[i]) : 32'hDEAD_0000,
          32'(e[i]));
  endtask

  int td;

  initial begin
    {d0.req_a, d0.req_b, d1.req_a, d1.req_b} = '0;
    {d0.freq_a, d0.freq_b, d1.freq_a, d1.freq_b} = '0;
    {d0.phase_a, d0.phase_b, d1.phase_a, d1.phase_b} = '0;
    tick(3);
    chk("rst.fsync", 32'(d0.FSYNC), 32'd1);
    chk("rst.sclk",  32'(d0.SCLK),  32'd1);
    chk("rst.sdata", 32'(d0.SDATA), 32'd0);
    chk("rst.busy",  32'(d0.busy),  32'd0);
    chk("rst.done",  32'(d0.done),  32'd0);
    chk("rst.ack_a", 32'(d0.ack_a), 32'd0);
    chk("rst.ack_b", 32'(d0.ack_b), 32'd0);
    chk("rst.owner", 32'(d0.owner), 32'd1);
    rst_n = 1'b1;
    tick(2);

    // single A transaction; data changed right after ack
    q0.delete(); b0 = 0; na0 = 0;
    d0.freq_a = 28'h1234567; d0.phase_a = 12'h800;
    d0.req_a = 1'b1;
    wait_for(0, "t1.ack_a");
    d0.req_a = 1'b0;
    d0.freq_a = 28'h0; d0.phase_a = 12'h0;
    wait_for(2, "t1.done");
    tick(2);
    chk("t1.busy_cycles", 32'(b0), 32'(T0));
    chk("t1.ack_pulses", 32'(na0), 32'd1);
    chk("t1.owner", 32'(d0.owner), 32'd0);
    chk_seq("t1", q0, 16'h4567, 16'h448D, 16'hC800);

    // CLK_DIV=1 instance, all-ones frequency
    q1.delete(); b1 = 0;
    d1.freq_b = 28'hFFFFFFF;
    d1.req_b = 1'b1;
    wait_for(3, "t5.ack_b");
    d1.req_b = 1'b0;
    wait_for(4, "t5.done");
    tick(2);
    chk("t5.busy_cycles", 32'(b1), 32'(T1));
    chk_seq("t5", q1, 16'h7FFF, 16'h7FFF, 16'hC000);

    // simultaneous requests after reset
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
    q0.delete();
    d0.freq_a = 28'h0003FFF;
    d0.freq_b = 28'hABCDEF0; d0.phase_b = 12'h123;
    d0.req_a = 1'b1; d0.req_b = 1'b1;
    wait_for(0, "t2.ack_a");
    chk("t2.no_ack_b", 32'(d0.ack_b), 32'd0);
    d0.req_a = 1'b0;
    wait_for(2, "t2.doneA");
    td = cyc;
    chk("t2.ownerA", 32'(d0.owner), 32'd0);
    chk_seq("t2a", q0, 16'h7FFF, 16'h4000, 16'hC000);
    q0.delete();
    wait_for(1, "t2.ack_b");
    chk("t2.ack_b_delay", 32'(cyc - td), 32'd2);
    d0.req_b = 1'b0;
    wait_for(2, "t2.doneB");
    chk("t2.ownerB", 32'(d0.owner), 32'd1);
    chk_seq("t2b", q0, 16'h5EF0, 16'h6AF3, 16'hC123);

    // both held: owners alternate A,B,A,B
    d0.req_a = 1'b1; d0.req_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_for(2, $sformatf("t3.done%0d", k));
      chk($sformatf("t3.owner%0d", k), 32'(d0.owner), 32'(k % 2));
    end
    d0.req_a = 1'b0; d0.req_b = 1'b0;
    tick(3);
    chk("t3.idle_busy", 32'(d0.busy), 32'd0);

    // reset in the middle of word 1
    d0.req_b = 1'b1;
    wait_for(1, "t4.ack_b0");
    d0.req_b = 1'b0;
    tick(88);
    chk("t4.mid_fsync", 32'(d0.FSYNC), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t4.rst_fsync", 32'(d0.FSYNC), 32'd1);
    chk("t4.rst_sclk",  32'(d0.SCLK),  32'd1);
    chk("t4.rst_busy",  32'(d0.busy),  32'd0);
    chk("t4.rst_owner", 32'(d0.owner), 32'd1);
    tick(2);
    rst_n = 1'b1;
    q0.delete(); b0 = 0;
    d0.req_b = 1'b1;
    wait_for(1, "t4.ack_b1");
    d0.req_b = 1'b0;
    wait_for(2, "t4.done");
    tick(2);
    chk("t4.busy_cycles", 32'(b0), 32'(T0));
    chk_seq("t4", q0, 16'h5EF0, 16'h6AF3, 16'hC123);

    // A pulses one cycle while B is busy
    d0.freq_a = 28'h0000001; d0.phase_a = 12'h000;
    d0.req_b = 1'b1;
    wait_for(1, "t6.ack_b");
    d0.req_b = 1'b0;
    tick(100);
    d0.req_a = 1'b1;
    tick(1);
    d0.req_a = 1'b0;
    wait_for(2, "t6.doneB");
    td = cyc;
    chk("t6.ownerB", 32'(d0.owner), 32'd1);
    q0.delete();
    wait_for(0, "t6.ack_a");
    chk("t6.ack_a_delay", 32'(cyc - td), 32'd2);
    d0.freq_a = 28'hFFFFFFF; d0.phase_a = 12'hFFF;
    wait_for(2, "t6.doneA");
    chk("t6.ownerA", 32'(d0.owner), 32'd0);
    chk_seq("t6", q0, 16'h4001, 16'h4000, 16'hC000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
